// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC into a zero-latency instruction memory and
// registers the returned word into the IF/ID register. Optional macro: FETCH_COUNT_EN.
module fetch_stage #(
    parameter int unsigned       AW        = 9,
    parameter int unsigned       DW        = 32,
    parameter logic [AW-1:0]     START_PC  = '0,
    parameter logic [DW-1:0]     HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic          if_valid,
    input  logic          id_ready,
    output logic          running,
    output logic          halted,
    output logic [31:0]   fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [AW-1:0] ifpc_q, ifpc_d;
    logic          vld_q, vld_d;
    logic          start_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            instr_q <= '0;
            ifpc_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        vld_d     = vld_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                vld_d = 1'b0;
                if (start) begin
                    state_d   = RUN;
                    pc_d      = START_PC;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (br_taken) begin
                    // Redirect wins over a stall so the wrong-path word is flushed.
                    pc_d  = br_target;
                    vld_d = 1'b0;
                end else if (vld_q && !id_ready) begin
                    vld_d = 1'b1;
                end else if (imem_data == HALT_WORD) begin
                    vld_d   = 1'b0;
                    state_d = HALT;
                end else begin
                    instr_d = imem_data;
                    ifpc_d  = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;
    assign if_valid  = vld_q;
    assign running   = (state_q == RUN);
    assign halted    = (state_q == HALT);

`ifdef FETCH_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc)
            cnt_d = '0;
        else if (vld_q && id_ready)
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign fetch_count = cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign fetch_count      = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, stall, branch flush, wrap, async reset, restart.
module tb_fetch_stage;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_valid;
    logic          id_ready;
    logic          running;
    logic          halted;
    logic [31:0]   fetch_count;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .br_taken(br_taken), .br_target(br_target),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .id_ready(id_ready), .running(running), .halted(halted),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ecnt(input int n);
`ifdef FETCH_COUNT_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out(input string tag, input logic [AW-1:0] pc, input logic [DW-1:0] ins);
        chk({tag, "_vld"}, {31'd0, if_valid}, 32'd1);
        chk({tag, "_pc"},  {23'd0, if_pc}, {23'd0, pc});
        chk({tag, "_ins"}, if_instr, ins);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'hFFFF_FFFF;
        mem[9'h40] = 32'h4040_4040; mem[9'h41] = 32'h0; mem[511] = 32'h5111_5111;

        rst = 1'b0; start = 1'b0; br_taken = 1'b0; br_target = '0; id_ready = 1'b0;
        step();
        chk("rst_vld", {31'd0, if_valid}, 32'd0);
        chk("rst_ins", if_instr, 32'd0);
        chk("rst_pc", {23'd0, if_pc}, 32'd0);
        chk("rst_addr", {23'd0, imem_addr}, 32'd0);
        chk("rst_state", {30'd0, running, halted}, 32'd0);
        chk("rst_cnt", fetch_count, 32'd0);
        rst = 1'b1;

        // IDLE ignores branch and ready
        br_taken = 1'b1; br_target = 9'h40; id_ready = 1'b1;
        step();
        chk("idle_addr", {23'd0, imem_addr}, 32'd0);
        chk("idle_vld", {31'd0, if_valid}, 32'd0);
        br_taken = 1'b0;

        // Basic fetch
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_run", {30'd0, running, halted}, 32'd2);
        chk("start_vld", {31'd0, if_valid}, 32'd0);
        step(); out("f0", 9'd0, 32'h11);
        step(); out("f1", 9'd1, 32'h22);
        step(); out("f2", 9'd2, 32'h33);
        step();
        chk("halt_state", {30'd0, running, halted}, 32'd1);
        chk("halt_addr", {23'd0, imem_addr}, 32'd3);
        chk("halt_vld", {31'd0, if_valid}, 32'd0);
        chk("halt_cnt", fetch_count, ecnt(3));

        // HALT ignores branch; restart with branch asserted alongside
        br_taken = 1'b1; br_target = 9'h40;
        step();
        chk("hbr_addr", {23'd0, imem_addr}, 32'd3);
        chk("hbr_state", {30'd0, running, halted}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0; br_taken = 1'b0;
        chk("rs_state", {30'd0, running, halted}, 32'd2);
        chk("rs_addr", {23'd0, imem_addr}, 32'd0);
        chk("rs_cnt", fetch_count, 32'd0);
        step(); out("rs0", 9'd0, 32'h11);
        step(); out("rs1", 9'd1, 32'h22);

        // Stall for three cycles
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            out("stall", 9'd1, 32'h22);
            chk("stall_addr", {23'd0, imem_addr}, 32'd2);
        end
        id_ready = 1'b1;
        step(); out("unstall", 9'd2, 32'h33);
        chk("unstall_cnt", fetch_count, ecnt(2));

        // Branch during stall flushes the held word
        id_ready = 1'b0; br_taken = 1'b1; br_target = 9'h40;
        step();
        br_taken = 1'b0; id_ready = 1'b1;
        chk("br_vld", {31'd0, if_valid}, 32'd0);
        chk("br_addr", {23'd0, imem_addr}, 32'h40);
        chk("br_cnt", fetch_count, ecnt(2));
        step(); out("br0", 9'h40, 32'h4040_4040);
        step(); out("nop", 9'h41, 32'h0);

        // Wrap from 511 to 0
        br_taken = 1'b1; br_target = 9'd511;
        step();
        br_taken = 1'b0;
        chk("wbr_vld", {31'd0, if_valid}, 32'd0);
        step(); out("w511", 9'd511, 32'h5111_5111);
        step(); out("w0", 9'd0, 32'h11);
        chk("w_addr", {23'd0, imem_addr}, 32'd1);
        chk("w_cnt", fetch_count, ecnt(5));

        // Async reset between edges
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", {31'd0, if_valid}, 32'd0);
        chk("arst_ins", if_instr, 32'd0);
        chk("arst_cnt", fetch_count, 32'd0);
        chk("arst_state", {30'd0, running, halted}, 32'd0);
        chk("arst_addr", {23'd0, imem_addr}, 32'd0);
        step();
        rst = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("ar_run", {30'd0, running, halted}, 32'd2);
        step(); out("ar0", 9'd0, 32'h11);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
